// File: rtl/seq_data_checker.sv
// seq_data_checker: locks on the first valid word and checks a contiguous +1 sequence, counting words and errors.
// Optional first-mismatch capture is enabled by defining SEQ_CHK_FIRST_ERR_CAPTURE_EN.
module seq_data_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int RESYNC_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     En,
  input  logic [DATA_WIDTH-1:0]    DataIn,
  input  logic                     DataInValid,
  output logic                     Locked,
  output logic                     ErrorFlag,
  output logic [ERR_CNT_WIDTH-1:0] ErrorCount,
  output logic [31:0]              WordCount,
  output logic [DATA_WIDTH-1:0]    FirstErrExpected,
  output logic [DATA_WIDTH-1:0]    FirstErrActual
);
  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;
  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_expected;
  logic [3:0]               r_miss;
  logic                     r_locked;
  logic                     r_err_flag;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [31:0]              r_word_cnt;
  logic [DATA_WIDTH-1:0]    w_data_nxt;
  logic [3:0]               w_miss_nxt;
  logic [ERR_CNT_WIDTH-1:0] w_err_inc;
  logic [31:0]              w_word_inc;
  logic                     w_match;
  assign w_data_nxt = DataIn + DATA_WIDTH'(1);
  assign w_miss_nxt = r_miss + 4'd1;
  assign w_err_inc  = &r_err_cnt ? r_err_cnt : r_err_cnt + ERR_CNT_WIDTH'(1);
  assign w_word_inc = &r_word_cnt ? r_word_cnt : r_word_cnt + 32'd1;
  assign w_match    = DataIn == r_expected;
`ifdef SEQ_CHK_FIRST_ERR_CAPTURE_EN
  logic [DATA_WIDTH-1:0] r_first_exp;
  logic [DATA_WIDTH-1:0] r_first_act;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_exp <= '0;
      r_first_act <= '0;
    end else if (En && r_state == IDLE) begin
      r_first_exp <= '0;
      r_first_act <= '0;
    end else if (En && r_state == CHECK && DataInValid && !w_match && !r_err_flag) begin
      r_first_exp <= r_expected;
      r_first_act <= DataIn;
    end
  end
  assign FirstErrExpected = r_first_exp;
  assign FirstErrActual   = r_first_act;
`else
  assign FirstErrExpected = '0;
  assign FirstErrActual   = '0;
`endif
  // En low parks the FSM but leaves results readable until the next run starts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_expected <= '0;
      r_miss     <= '0;
      r_locked   <= 1'b0;
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (!En) begin
      r_state  <= IDLE;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_err_cnt  <= '0;
          r_word_cnt <= '0;
          r_err_flag <= 1'b0;
          r_miss     <= '0;
          r_state    <= SYNC;
        end
        SYNC: if (DataInValid) begin
          r_expected <= w_data_nxt;
          r_word_cnt <= w_word_inc;
          r_miss     <= '0;
          r_locked   <= 1'b1;
          r_state    <= CHECK;
        end
        CHECK: if (DataInValid) begin
          r_expected <= w_data_nxt;
          r_word_cnt <= w_word_inc;
          if (w_match) r_miss <= '0;
          else begin
            r_err_cnt  <= w_err_inc;
            r_err_flag <= 1'b1;
            r_miss     <= w_miss_nxt == 4'(RESYNC_THRESH) ? 4'd0 : w_miss_nxt;
            if (w_miss_nxt == 4'(RESYNC_THRESH)) begin
              r_locked <= 1'b0;
              r_state  <= SYNC;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign Locked     = r_locked;
  assign ErrorFlag  = r_err_flag;
  assign ErrorCount = r_err_cnt;
  assign WordCount  = r_word_cnt;
endmodule

// File: tb/tb_seq_data_checker.sv
// tb_seq_data_checker: directed vectors against a default instance and a small saturating-counter instance.
module tb_seq_data_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        En = 1'b0;
  logic [31:0] DataIn = '0;
  logic        DataInValid = 1'b0;
  logic        locked, err_flag;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt, first_exp, first_act;
  logic        s_locked, s_err_flag;
  logic [3:0]  s_err_cnt;
  logic [31:0] s_word_cnt, s_first_exp, s_first_act;
  int          n_vec = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  seq_data_checker dut (
    .clk(clk), .rst(rst), .En(En), .DataIn(DataIn), .DataInValid(DataInValid),
    .Locked(locked), .ErrorFlag(err_flag), .ErrorCount(err_cnt), .WordCount(word_cnt),
    .FirstErrExpected(first_exp), .FirstErrActual(first_act)
  );
  seq_data_checker #(.ERR_CNT_WIDTH(4), .RESYNC_THRESH(15)) dut_sat (
    .clk(clk), .rst(rst), .En(En), .DataIn(DataIn), .DataInValid(DataInValid),
    .Locked(s_locked), .ErrorFlag(s_err_flag), .ErrorCount(s_err_cnt), .WordCount(s_word_cnt),
    .FirstErrExpected(s_first_exp), .FirstErrActual(s_first_act)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic en, input logic v, input logic [31:0] d);
    En = en;
    DataInValid = v;
    DataIn = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    check("rst_locked", 64'(locked), 0);
    check("rst_flag", 64'(err_flag), 0);
    check("rst_errcnt", 64'(err_cnt), 0);
    check("rst_wordcnt", 64'(word_cnt), 0);
    check("rst_first_exp", 64'(first_exp), 0);
    // clean run
    step(1, 0, 0);
    check("idle_not_locked", 64'(locked), 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 32'(i));
      if (i == 0) check("clean_lock", 64'(locked), 1);
    end
    check("clean_wordcnt", 64'(word_cnt), 100);
    check("clean_errcnt", 64'(err_cnt), 0);
    check("clean_flag", 64'(err_flag), 0);
    step(0, 0, 0);
    check("enlow_unlock", 64'(locked), 0);
    check("enlow_hold_wc", 64'(word_cnt), 100);
    // single drop
    step(1, 0, 0);
    check("newrun_clear_wc", 64'(word_cnt), 0);
    for (int i = 0; i <= 20; i++) if (i != 10) step(1, 1, 32'(i));
    check("drop_errcnt", 64'(err_cnt), 1);
    check("drop_flag", 64'(err_flag), 1);
    check("drop_locked", 64'(locked), 1);
    check("drop_wordcnt", 64'(word_cnt), 20);
`ifdef SEQ_CHK_FIRST_ERR_CAPTURE_EN
    check("drop_first_exp", 64'(first_exp), 10);
    check("drop_first_act", 64'(first_act), 11);
`else
    check("drop_first_exp", 64'(first_exp), 0);
    check("drop_first_act", 64'(first_act), 0);
`endif
    // wrap with gaps
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 32'hFFFF_FFFD + 32'(k));
      step(1, 0, 32'h1234_5678);
    end
    check("wrap_errcnt", 64'(err_cnt), 0);
    check("wrap_wordcnt", 64'(word_cnt), 5);
    check("wrap_locked", 64'(locked), 1);
    // resync: expected is now 2
    step(1, 1, 100);
    step(1, 1, 200);
    step(1, 1, 300);
    check("resync_3bad_locked", 64'(locked), 1);
    step(1, 1, 400);
    check("resync_4bad_unlocked", 64'(locked), 0);
    check("resync_errcnt4", 64'(err_cnt), 4);
    step(1, 1, 50);
    check("resync_relock", 64'(locked), 1);
    step(1, 1, 51);
    step(1, 1, 52);
    check("resync_final_errcnt", 64'(err_cnt), 4);
    check("resync_wordcnt", 64'(word_cnt), 12);
`ifdef SEQ_CHK_FIRST_ERR_CAPTURE_EN
    check("resync_first_exp", 64'(first_exp), 2);
    check("resync_first_act", 64'(first_act), 100);
`endif
    // run boundary
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 32'(i));
    step(1, 1, 10);
    step(1, 1, 20);
    step(1, 1, 30);
    step(1, 1, 31);
    check("bound_errcnt", 64'(err_cnt), 3);
    for (int i = 0; i < 5; i++) step(0, 1, 32'(99 + i));
    check("bound_hold_errcnt", 64'(err_cnt), 3);
    check("bound_hold_wc", 64'(word_cnt), 9);
    check("bound_hold_flag", 64'(err_flag), 1);
    check("bound_idle_locked", 64'(locked), 0);
    step(1, 0, 0);
    check("bound_clear_errcnt", 64'(err_cnt), 0);
    check("bound_clear_wc", 64'(word_cnt), 0);
    check("bound_clear_flag", 64'(err_flag), 0);
    // reset mid-run
    step(1, 1, 7);
    step(1, 1, 9);
    check("midrun_pre_errcnt", 64'(err_cnt), 1);
    rst = 1'b1;
    step(1, 1, 10);
    rst = 1'b0;
    check("midrun_rst_locked", 64'(locked), 0);
    check("midrun_rst_errcnt", 64'(err_cnt), 0);
    check("midrun_rst_wc", 64'(word_cnt), 0);
    step(1, 1, 11);
    check("midrun_valid_in_idle", 64'(word_cnt), 0);
    // saturation: 21 words stepping by 2, every post-lock word mismatches
    for (int i = 0; i <= 20; i++) begin
      step(1, 1, 32'(2 * i));
      if (i == 15) check("sat_resync_at15", 64'(s_locked), 0);
    end
    check("sat_errcnt", 64'(s_err_cnt), 15);
    check("sat_wordcnt", 64'(s_word_cnt), 21);
    check("sat_locked", 64'(s_locked), 1);
    check("multi_resync_errcnt", 64'(err_cnt), 16);
    check("multi_resync_locked", 64'(locked), 1);
    step(1, 1, 1000);
    check("sat_hold", 64'(s_err_cnt), 15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_data_checker.md
Name: seq_data_checker

Overview:
- Consumer-side partner of the simulation data generator; sits at the FIFO/DDR read output in the loopback test path.
- Checks that valid words form a contiguous +1 sequence and locks onto the first valid word received.
- Counts words and errors, keeps a sticky error flag, and re-syncs after repeated mismatches.
- All results are registered and held after the run ends, so software or the bench can read them.

Parameters:
- DATA_WIDTH, 32, width of checked data word.
- ERR_CNT_WIDTH, 16, width of saturating error counter.
- RESYNC_THRESH, 4, consecutive mismatches that drop lock and return to SYNC (legal range 1..15).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- En  input  1  run enable; high = checking run active.
- DataIn  input  DATA_WIDTH  word under test.
- DataInValid  input  1  DataIn qualifier; gaps allowed.
- Locked  output  1  high while in CHECK state.
- ErrorFlag  output  1  sticky; set on first mismatch of the run.
- ErrorCount  output  ERR_CNT_WIDTH  mismatches this run, saturating at all-ones.
- WordCount  output  32  valid words checked this run, saturating at all-ones.
- FirstErrExpected  output  DATA_WIDTH  expected value at first mismatch.
- FirstErrActual  output  DATA_WIDTH  received value at first mismatch.

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal Expected=0, MissCnt=0.
- All outputs are registered and update 1 clk after the qualifying input cycle.
- States: IDLE, SYNC, CHECK.
- En low, any state: next state=IDLE, Locked=0. Counters, flags and captures hold.
- En low dominates: a DataInValid arriving in the same cycle is ignored.
- IDLE, En high: clear ErrorCount, WordCount, ErrorFlag, MissCnt, FirstErr*; go to SYNC.
  - The first valid word of a run is therefore never consumed in IDLE; it is taken in SYNC at the earliest.
- SYNC, valid: Expected<=DataIn+1; WordCount+1; MissCnt=0; go to CHECK; Locked<=1. No compare.
- CHECK, DataInValid low: no state change.
- CHECK, valid and DataIn==Expected:
  - Expected+1; WordCount+1; MissCnt<=0.
- CHECK, valid and DataIn!=Expected:
  - ErrorCount+1 (saturating); ErrorFlag<=1; WordCount+1.
  - Expected<=DataIn+1, i.e. re-align, so a single dropped or duplicated word costs exactly 1 error.
  - MissCnt+1. If MissCnt+1==RESYNC_THRESH: go to SYNC, Locked<=0, MissCnt<=0.
- Arithmetic:
  - Expected is modulo 2^DATA_WIDTH; all-ones followed by 0 is a match.
  - Counters saturate; they never wrap.
- rst mid-run: same as power-up reset. Next run requires En high after reset.

Optional Feature:
- Macro: SEQ_CHK_FIRST_ERR_CAPTURE_EN.
- Defined: on the first mismatch of a run (ErrorFlag 0→1 transition), latch Expected into FirstErrExpected and DataIn into FirstErrActual. Hold until the next run start or reset.
- Not defined: FirstErrExpected and FirstErrActual are tied to 0. No capture registers are synthesised. Ports remain present.

Test Plan:
- Clean run: rst, then En=1 with gen-style data 0,1,2,...,99 valid continuously → Locked=1 from cycle after word 0; WordCount=100; ErrorCount=0; ErrorFlag=0.
- Single drop: sequence 0..9,11..20 → ErrorCount=1; ErrorFlag=1; Locked stays 1; WordCount=20; with macro FirstErrExpected=10, FirstErrActual=11.
- Wrap and gaps: start at 0xFFFFFFFD, 5 words with DataInValid toggling 1/0 → ErrorCount=0; WordCount=5; Expected passes through 0xFFFFFFFF→0.
- Resync: locked, then 4 words with random data, each differing from its re-aligned expected, then 50,51,52 → ErrorCount=4; Locked=0 after 4th bad word; word 50 re-syncs (Locked=1); 51, 52 match; final ErrorCount=4; WordCount=total valid words.
- Run boundary: finish a run with ErrorCount=3; drop En for 5 cycles → counts hold at 3. Raise En → all clear to 0 one cycle later. Assert valid together with En low → ignored.
- Saturation: ERR_CNT_WIDTH=4 override, 20 mismatching words with RESYNC_THRESH=15 → ErrorCount=15 and holds.
